w0rm_fetch_unit: RTL and testbench
==================================

Name: w0rm_fetch_unit

Overview:
Instruction-fetch initiator for the W0RM core. It drives the instruction read port of core memory (addr/read/valid request, 16-bit data plus valid response, fixed 1-cycle read latency) and keeps a sequential PC. Fetched halfwords are buffered in a small prefetch FIFO with their PCs and handed to decode through a valid/ready handshake. A branch redirect flushes the FIFO and any in-flight response.

Parameters:
ADDR_WIDTH, 32, PC and memory address width
INST_WIDTH, 16, instruction width; PC increments by INST_WIDTH/8 = 2
RESET_VECTOR, 32'h20000000, first fetch address after reset
FIFO_DEPTH, 4, prefetch entries; power of 2, at least 2

Ports:
clk  in  1  core clock; all state on rising edge
reset_n  in  1  asynchronous, active-low reset
mem_addr  out  ADDR_WIDTH  fetch address
mem_read  out  1  read request
mem_valid_out  out  1  request qualifier; asserted together with mem_read
mem_data_in  in  INST_WIDTH  returned instruction
mem_valid_in  in  1  response valid, exactly 1 cycle after the request
dec_inst  out  INST_WIDTH  instruction at FIFO head
dec_pc  out  ADDR_WIDTH  PC of dec_inst
dec_valid  out  1  FIFO head valid
dec_ready  in  1  decode accepts head this cycle
branch_valid  in  1  redirect request
branch_target  in  ADDR_WIDTH  redirect PC; bit 0 ignored and forced to 0
fetch_fault  out  1  sticky missing-response error

Behaviour:
- Reset (async assert, sync release): pc=RESET_VECTOR, FIFO empty, no request in flight, fault=0. Outputs: mem_read=0, mem_valid_out=0, mem_addr=RESET_VECTOR, dec_valid=0, dec_inst=0, dec_pc=0, fetch_fault=0.
- States: RUN, FAULT. Reset goes to RUN.
- Issue (RUN): mem_read=mem_valid_out=1 with mem_addr=pc when occupancy + inflight < FIFO_DEPTH and branch_valid=0. On issue: pc += 2 (wraps modulo 2^ADDR_WIDTH), inflight<=1, and req_pc is recorded.
- Count occupancy after a simultaneous pop. With dec_ready=1 every cycle, issue sustains one fetch per cycle.
- Response: when inflight=1 and mem_valid_in=1, push {mem_data_in, req_pc} into the FIFO. Never push when inflight=0; a stray mem_valid_in is ignored.
- Missing response: inflight=1 and mem_valid_in=0 moves to FAULT. fetch_fault=1 (sticky), issue stops, and the FIFO still drains to decode.
- Pop: dec_valid=1 and dec_ready=1 removes the head. dec_inst and dec_pc come from registered FIFO head storage, so push-to-dec_valid latency is 1 cycle.
- Push and pop in the same cycle: occupancy is unchanged. On an empty FIFO the pushed entry appears next cycle (no bypass).
- Full FIFO: issue is inhibited by the credit rule, so no overflow is possible.
- Branch (any state, highest priority):
  - FIFO is cleared and dec_valid=0 next cycle.
  - An inflight response arriving the next cycle is dropped.
  - pc <= {branch_target[AW-1:1],0}, FAULT is left for RUN, fetch_fault is cleared.
  - No issue in the branch cycle; the first fetch of the target happens the following cycle.
- Branch together with dec_ready: the pop is irrelevant because the flush wins.
- Reset mid-operation clears everything immediately, including inflight; any later mem_valid_in is ignored.
- Pointers are log2(FIFO_DEPTH)+1 bits wide, so full and empty are distinguished by the MSB.

Decomposition:
- Shared package w0rm_pkg: RESET_VECTOR default, INST_BYTES=2, fetch state encoding.
- Sub-module w0rm_sync_fifo: synchronous FIFO, parameters WIDTH and DEPTH, with push, pop, flush, full, empty, count and registered head. Instantiate it with WIDTH = INST_WIDTH + ADDR_WIDTH.

Test Plan:
- Reset then streaming: release reset with dec_ready=1 and the memory model returning data = addr[15:0].
  - mem_addr is 0x20000000, 0x20000002, 0x20000004… on consecutive cycles.
  - dec_pc/dec_inst pairs match, with the first dec_valid 2 cycles after the first request.
- Backpressure: dec_ready=0 for 10 cycles.
  - Exactly 4 requests are issued, then mem_read=0.
  - After dec_ready=1, entries drain in order 0x20000000..06 and fetch resumes with no loss or duplication.
- Branch with a response in flight: branch_valid=1, target 0x20000101, in the cycle after a request to 0x20000008.
  - The response for 0x20000008 is dropped and dec_valid=0.
  - The next request is 0x20000100, and the first dec_pc after that is 0x20000100.
- Missing response: the model withholds mem_valid_in once.
  - fetch_fault=1, no further requests, buffered entries still delivered.
  - A branch to 0x20000000 clears the fault and restarts fetch.
- Reset mid-stream: assert reset_n=0 asynchronously between edges.
  - All outputs go to reset values immediately.
  - After release, the first request is at 0x20000000 and a late mem_valid_in pulse is not pushed.
- Wrap-around: branch to 0xFFFFFFFE.
  - Next requests are 0xFFFFFFFE, then 0x00000000.

Source files
------------

// File: rtl/w0rm_pkg.sv
// Shared definitions for the W0RM instruction-fetch path.
package w0rm_pkg;

  // First fetch address after reset.
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h2000_0000;

  // Bytes per instruction; the PC advances by this much per fetch.
  localparam int INST_BYTES = 2;

  // Fetch control state. FAULT is entered when a request gets no response.
  typedef enum logic {
    FETCH_RUN   = 1'b0,
    FETCH_FAULT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/w0rm_sync_fifo.sv
// Synchronous FIFO with flush and a registered head.
// Pointers carry one extra MSB so that full and empty can be told apart.
// The head register is updated in the same edge as the push/pop, so a push
// into an empty FIFO is visible on head_o one cycle later (no bypass).
module w0rm_sync_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW-1:0]    rd_ptr_inc;
  logic [WIDTH-1:0] head_q;
  logic             do_push;
  logic             do_pop;

  assign count_o    = wr_ptr_q - rd_ptr_q;
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (count_o == PW'(DEPTH));
  assign head_o     = head_q;
  assign rd_ptr_inc = rd_ptr_q + PTR_ONE;

  // Flush overrides both push and pop.
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  // Storage array: written on push, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[IW-1:0]] <= din_i;
    end
  end

  // Pointer and registered-head maintenance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_inc;
      if (do_pop) begin
        // Next head is the following stored entry, or the incoming one
        // when the FIFO held a single entry.
        if (count_o > PTR_ONE) begin
          head_q <= mem_q[rd_ptr_inc[IW-1:0]];
        end else if (do_push) begin
          head_q <= din_i;
        end
      end else if (empty_o && do_push) begin
        head_q <= din_i;
      end
    end
  end

endmodule

// File: rtl/w0rm_fetch_unit.sv
// W0RM instruction-fetch initiator: sequential PC, one-cycle-latency
// instruction reads, prefetch FIFO toward decode, and branch redirect.
// The first request is issued the cycle after reset is released, so the
// request outputs are at their idle values while reset is asserted.
module w0rm_fetch_unit
  import w0rm_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    INST_WIDTH   = 8 * INST_BYTES,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(RESET_VECTOR_DEFAULT),
  parameter int                    FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read,
  output logic                  mem_valid_out,
  input  logic [INST_WIDTH-1:0] mem_data_in,
  input  logic                  mem_valid_in,
  output logic [INST_WIDTH-1:0] dec_inst,
  output logic [ADDR_WIDTH-1:0] dec_pc,
  output logic                  dec_valid,
  input  logic                  dec_ready,
  input  logic                  branch_valid,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic                  fetch_fault
);

  // Handshakes:
  //   memory  - a request (mem_read & mem_valid_out, addr = mem_addr) is
  //             answered by mem_valid_in exactly one cycle later; a
  //             response with no request outstanding is ignored.
  //   decode  - the head entry transfers on a cycle with dec_valid &
  //             dec_ready; dec_inst/dec_pc stay stable while dec_valid is
  //             high and dec_ready is low.

  localparam int FW = INST_WIDTH + ADDR_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(INST_WIDTH / 8);

  fetch_state_e          state_q;
  logic                  armed_q;
  logic                  inflight_q;
  logic                  fault_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] req_pc_q;

  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [FW-1:0]         fifo_head;
  logic                  pop;
  logic                  push;
  logic                  missing;
  logic                  issue;
  logic [CW:0]           demand;
  logic                  unused_target_lsb;

  // Bit 0 of the redirect target is forced to zero.
  assign unused_target_lsb = branch_target[0];

  assign pop = !fifo_empty && dec_ready;

  // Slots needed after this cycle: entries left after a pop plus the one
  // response still owed by memory.
  assign demand = {1'b0, fifo_count} - {{CW{1'b0}}, pop} + {{CW{1'b0}}, inflight_q};

  // Request issue: only in RUN, never in a redirect cycle, and only with a
  // free FIFO slot for the answer.
  assign issue = armed_q && (state_q == FETCH_RUN) && !branch_valid &&
                 (demand < (CW + 1)'(FIFO_DEPTH));

  // Responses are kept only when owed and not being flushed.
  assign push    = inflight_q && mem_valid_in && (state_q == FETCH_RUN) &&
                   !branch_valid && !fifo_full;
  assign missing = inflight_q && !mem_valid_in && (state_q == FETCH_RUN);

  assign mem_addr      = pc_q;
  assign mem_read      = issue;
  assign mem_valid_out = issue;
  assign dec_valid     = !fifo_empty;
  assign dec_inst      = fifo_head[FW-1 -: INST_WIDTH];
  assign dec_pc        = fifo_head[ADDR_WIDTH-1:0];
  assign fetch_fault   = fault_q;

  w0rm_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .din_i   ({mem_data_in, req_pc_q}),
    .pop_i   (pop),
    .flush_i (branch_valid),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Fetch FSM: PC, in-flight tracking, sticky fault and branch redirect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= FETCH_RUN;
      armed_q    <= 1'b0;
      inflight_q <= 1'b0;
      fault_q    <= 1'b0;
      pc_q       <= RESET_VECTOR;
      req_pc_q   <= '0;
    end else begin
      armed_q    <= 1'b1;
      inflight_q <= issue;
      if (issue) begin
        pc_q     <= pc_q + PC_STEP;
        req_pc_q <= pc_q;
      end
      if (branch_valid) begin
        pc_q    <= {branch_target[ADDR_WIDTH-1:1], 1'b0};
        state_q <= FETCH_RUN;
        fault_q <= 1'b0;
      end else begin
        case (state_q)
          FETCH_RUN: begin
            if (missing) begin
              state_q <= FETCH_FAULT;
              fault_q <= 1'b1;
            end
          end
          FETCH_FAULT: begin
            state_q <= FETCH_FAULT;
          end
          default: begin
            state_q <= FETCH_RUN;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_w0rm_fetch_unit.sv
// Bench for w0rm_fetch_unit: memory model answering with data = addr[15:0],
// scoreboard queue of expected decode entries, table of redirect vectors
// and hand-written sequences for backpressure, missing response and reset.
module tb_w0rm_fetch_unit;

  localparam int          AW    = 32;
  localparam int          IW    = 16;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RV    = 32'h2000_0000;

  // Clock/reset and DUT signals
  logic          clk;
  logic          reset_n;
  logic [AW-1:0] mem_addr;
  logic          mem_read;
  logic          mem_valid_out;
  logic [IW-1:0] mem_data_in;
  logic          mem_valid_in;
  logic [IW-1:0] dec_inst;
  logic [AW-1:0] dec_pc;
  logic          dec_valid;
  logic          dec_ready;
  logic          branch_valid;
  logic [AW-1:0] branch_target;
  logic          fetch_fault;

  w0rm_fetch_unit #(
    .ADDR_WIDTH   (AW),
    .INST_WIDTH   (IW),
    .RESET_VECTOR (RV),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .mem_addr      (mem_addr),
    .mem_read      (mem_read),
    .mem_valid_out (mem_valid_out),
    .mem_data_in   (mem_data_in),
    .mem_valid_in  (mem_valid_in),
    .dec_inst      (dec_inst),
    .dec_pc        (dec_pc),
    .dec_valid     (dec_valid),
    .dec_ready     (dec_ready),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .fetch_fault   (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard and model state
  logic [47:0] exp_q[$];
  logic [31:0] exp_pc;
  logic [31:0] resp_addr;
  bit          model_fault;
  bit          armed_m;
  bit          resp_pending;
  bit          withhold;
  int          errors;
  int          checks;
  int          req_count;

  // Values sampled in the most recent tick
  logic        s_mem_read;
  logic [31:0] s_mem_addr;
  logic        s_dec_valid;
  logic [31:0] s_dec_pc;
  logic        s_fault;

  typedef struct {
    logic [31:0] target;
    logic [31:0] exp_addr0;
    logic [31:0] exp_addr1;
  } br_vec_t;

  br_vec_t br_tbl[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_mem_read", 64'(mem_read), 64'(0));
    check("rst_mem_valid_out", 64'(mem_valid_out), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(RV));
    check("rst_dec_valid", 64'(dec_valid), 64'(0));
    check("rst_dec_inst", 64'(dec_inst), 64'(0));
    check("rst_dec_pc", 64'(dec_pc), 64'(0));
    check("rst_fetch_fault", 64'(fetch_fault), 64'(0));
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_pc       = RV;
    model_fault  = 1'b0;
    armed_m      = 1'b0;
    resp_pending = 1'b0;
    withhold     = 1'b0;
  endtask

  task automatic apply_reset();
    reset_n       = 1'b0;
    dec_ready     = 1'b0;
    branch_valid  = 1'b0;
    branch_target = '0;
    mem_valid_in  = 1'b0;
    mem_data_in   = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One clock cycle: check outputs against the model, update the
  // scoreboard, then drive next-cycle memory response.
  task automatic tick();
    int          occ;
    bit          pop_m;
    bit          exp_issue;
    bit          next_fault;
    bit          next_resp;
    logic [31:0] next_addr;
    logic [47:0] head;
    #1;
    s_mem_read  = mem_read;
    s_mem_addr  = mem_addr;
    s_dec_valid = dec_valid;
    s_dec_pc    = dec_pc;
    s_fault     = fetch_fault;
    occ = exp_q.size();
    check("dec_valid", 64'(dec_valid), 64'(occ != 0));
    if (occ != 0) begin
      head = exp_q[0];
      check("dec_inst", 64'(dec_inst), 64'(head[47:32]));
      check("dec_pc", 64'(dec_pc), 64'(head[31:0]));
    end
    pop_m     = (occ != 0) && dec_ready && !branch_valid;
    exp_issue = armed_m && !model_fault && !branch_valid &&
                ((occ - int'(pop_m) + int'(resp_pending)) < DEPTH);
    check("mem_read", 64'(mem_read), 64'(exp_issue));
    check("mem_valid_out", 64'(mem_valid_out), 64'(exp_issue));
    if (mem_read) begin
      check("mem_addr", 64'(mem_addr), 64'(exp_pc));
      req_count++;
    end
    check("fetch_fault", 64'(fetch_fault), 64'(model_fault));
    if (pop_m) void'(exp_q.pop_front());
    if (resp_pending && mem_valid_in && !branch_valid && !model_fault)
      exp_q.push_back({mem_data_in, resp_addr});
    next_fault = model_fault;
    if (branch_valid) begin
      exp_q.delete();
      exp_pc     = {branch_target[31:1], 1'b0};
      next_fault = 1'b0;
    end else begin
      if (resp_pending && !mem_valid_in && !model_fault) next_fault = 1'b1;
      if (mem_read) exp_pc = exp_pc + 32'd2;
    end
    next_resp = mem_read;
    next_addr = mem_addr;
    @(posedge clk);
    armed_m     = 1'b1;
    model_fault = next_fault;
    @(negedge clk);
    mem_valid_in = next_resp && !withhold;
    if (next_resp) withhold = 1'b0;
    mem_data_in  = next_addr[15:0];
    resp_pending = next_resp;
    resp_addr    = next_addr;
  endtask

  task automatic do_branch(input logic [31:0] target);
    branch_valid  = 1'b1;
    branch_target = target;
    tick();
    branch_valid  = 1'b0;
    branch_target = '0;
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_req;
    int first_dv;
    int drain_cnt;
    bit found;
    logic [31:0] first_addr;

    errors    = 0;
    checks    = 0;
    req_count = 0;
    br_tbl[0] = '{target: 32'hFFFF_FFFE, exp_addr0: 32'hFFFF_FFFE, exp_addr1: 32'h0000_0000};
    br_tbl[1] = '{target: 32'h0000_0003, exp_addr0: 32'h0000_0002, exp_addr1: 32'h0000_0004};
    br_tbl[2] = '{target: 32'h1234_5679, exp_addr0: 32'h1234_5678, exp_addr1: 32'h1234_567A};
    br_tbl[3] = '{target: 32'h8000_0000, exp_addr0: 32'h8000_0000, exp_addr1: 32'h8000_0002};

    // Reset state
    apply_reset();
    check_reset_outputs();

    // Streaming with decode always ready
    dec_ready  = 1'b1;
    first_req  = -1;
    first_dv   = -1;
    first_addr = '0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (first_req < 0 && s_mem_read) begin
        first_req  = i;
        first_addr = s_mem_addr;
      end
      if (first_dv < 0 && s_dec_valid) first_dv = i;
    end
    check("stream_first_addr", 64'(first_addr), 64'(RV));
    check("stream_dec_latency", 64'(first_dv - first_req), 64'(2));

    // Backpressure: exactly DEPTH requests, then drain in order
    apply_reset();
    dec_ready = 1'b0;
    req_count = 0;
    for (int i = 0; i < 10; i++) tick();
    check("bp_req_count", 64'(req_count), 64'(4));
    check("bp_idle", 64'(s_mem_read), 64'(0));
    dec_ready = 1'b1;
    tick();
    check("bp_first_drain_pc", 64'(s_dec_pc), 64'(RV));
    for (int i = 0; i < 11; i++) tick();

    // Branch with a response in flight
    apply_reset();
    dec_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      tick();
      if (s_mem_read && s_mem_addr == 32'h2000_0008) found = 1'b1;
    end
    check("br_reached_0x08", 64'(found), 64'(1));
    do_branch(32'h2000_0101);
    tick();
    check("br_dec_flushed", 64'(s_dec_valid), 64'(0));
    check("br_first_req_valid", 64'(s_mem_read), 64'(1));
    check("br_first_req_addr", 64'(s_mem_addr), 64'(32'h2000_0100));
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (s_dec_valid) found = 1'b1;
    end
    check("br_dec_seen", 64'(found), 64'(1));
    check("br_first_dec_pc", 64'(s_dec_pc), 64'(32'h2000_0100));

    // Redirect table, including PC wrap-around
    for (int v = 0; v < 4; v++) begin
      do_branch(br_tbl[v].target);
      tick();
      check("tbl_dec_flushed", 64'(s_dec_valid), 64'(0));
      check("tbl_req0_valid", 64'(s_mem_read), 64'(1));
      check("tbl_req0_addr", 64'(s_mem_addr), 64'(br_tbl[v].exp_addr0));
      tick();
      check("tbl_req1_addr", 64'(s_mem_addr), 64'(br_tbl[v].exp_addr1));
      for (int i = 0; i < 3; i++) tick();
    end

    // Missing response: fault, no issue, buffered entries still delivered
    dec_ready = 1'b0;
    do_branch(32'h2000_0040);
    tick();
    tick();
    withhold = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) tick();
    check("fault_set", 64'(s_fault), 64'(1));
    req_count = 0;
    for (int i = 0; i < 4; i++) tick();
    check("fault_no_req", 64'(req_count), 64'(0));
    dec_ready = 1'b1;
    drain_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (s_dec_valid) drain_cnt++;
    end
    check("fault_drain_count", 64'(drain_cnt), 64'(2));
    check("fault_drain_empty", 64'(s_dec_valid), 64'(0));
    do_branch(RV);
    tick();
    check("fault_cleared", 64'(s_fault), 64'(0));
    check("fault_restart_valid", 64'(s_mem_read), 64'(1));
    check("fault_restart_addr", 64'(s_mem_addr), 64'(RV));
    for (int i = 0; i < 6; i++) tick();

    // Asynchronous reset mid-stream, then a stray response pulse
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_outputs();
    mem_valid_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n      = 1'b1;
    mem_valid_in = 1'b1;
    mem_data_in  = 16'hBEEF;
    tick();
    check("rst_release_idle", 64'(s_mem_read), 64'(0));
    tick();
    check("rst_first_req_valid", 64'(s_mem_read), 64'(1));
    check("rst_first_req_addr", 64'(s_mem_addr), 64'(RV));
    check("rst_stray_not_pushed", 64'(s_dec_valid), 64'(0));
    for (int i = 0; i < 6; i++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
